dtmr_sched: RTL and testbench

- Sequential scheduler for the dynamic TMR datapath. It drives the three PMC enables and the voter `state` select that the purely combinational TMR control block produces today.
- Adds four things:
  - hysteresis on entering and leaving TMR;
  - a warm-up window before voting starts;
  - per-module fault counting with quarantine;
  - wear-levelling rotation of the single active module in simplex mode.
- Sits between the sensor/error inputs and the PMC/voter group, and consumes the voter `fault` vector as feedback.

---
 rtl/dtmr_sched_if.sv | 26 ++
 rtl/dtmr_sched.sv | 213 +++++++++++++++++++++
 tb/tb_dtmr_sched.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dtmr_sched_if.sv
// Handshake bundle between the dynamic TMR scheduler and its surroundings:
// sensor/error inputs, voter fault feedback and the PMC/voter control outputs.
interface dtmr_sched_if;
    logic [3:0] err_rate;
    logic       f1;
    logic       f2;
    logic       b1;
    logic       b2;
    logic [2:0] fault;
    logic       clr_quar;
    logic [2:0] en;
    logic       state;
    logic [2:0] quar;
    logic       alarm;
    logic [1:0] fsm_o;

    modport master (
        output err_rate, f1, f2, b1, b2, fault, clr_quar,
        input  en, state, quar, alarm, fsm_o
    );

    modport slave (
        input  err_rate, f1, f2, b1, b2, fault, clr_quar,
        output en, state, quar, alarm, fsm_o
    );
endinterface

// File: rtl/dtmr_sched.sv
// Sequential scheduler for the dynamic TMR datapath: PMC enables and voter mode with
// enter/leave hysteresis, warm-up, per-module fault quarantine and simplex wear-levelling.
module dtmr_sched #(
    parameter logic [3:0]  ERR_HI     = 4'd8,
    parameter logic [3:0]  ERR_LO     = 4'd4,
    parameter int unsigned HOLD       = 8,
    parameter int unsigned WARM       = 4,
    parameter int unsigned FAULT_LIM  = 3,
    parameter int unsigned ROT_PERIOD = 16
) (
    input  logic        clk,
    input  logic        rst,
    dtmr_sched_if.slave bus
);

    localparam int CW = 8;
    localparam logic [CW-1:0] ZERO_C    = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
    localparam logic [CW-1:0] WARM_LAST = CW'(WARM - 1);
    localparam logic [CW-1:0] ROT_LAST  = CW'(ROT_PERIOD - 1);
    localparam logic [CW-1:0] FLIM_C    = CW'(FAULT_LIM);

    typedef enum logic [1:0] {
        ST_SIMPLEX  = 2'd0,
        ST_WARMUP   = 2'd1,
        ST_TMR      = 2'd2,
        ST_DEGRADED = 2'd3
    } fsm_t;

    fsm_t                 fsm_r, fsm_s;
    logic [1:0]           ptr_r, ptr_s;
    logic [2:0]           quar_r, quar_s;
    logic [CW-1:0]        rot_r, rot_s;
    logic [CW-1:0]        warm_r, warm_s;
    logic [CW-1:0]        calm_r, calm_s;
    logic [2:0][CW-1:0]   fcnt_r, fcnt_s;
    logic [2:0]           en_r, en_s;
    logic                 state_r, state_s;
    logic                 alarm_r, alarm_s;
    logic                 sens_s;
    logic                 trig_s;
    logic                 calm_in_s;

    function automatic logic [2:0] onehot(input logic [1:0] idx);
        logic [2:0] r;
        case (idx)
            2'd0:    r = 3'b001;
            2'd1:    r = 3'b010;
            2'd2:    r = 3'b100;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    // Index 0 is also returned when nothing is healthy; callers gate en separately.
    function automatic logic [1:0] lowest_healthy(input logic [2:0] q);
        logic [1:0] r;
        if (!q[0])      r = 2'd0;
        else if (!q[1]) r = 2'd1;
        else if (!q[2]) r = 2'd2;
        else            r = 2'd0;
        return r;
    endfunction

    function automatic logic [1:0] next_healthy(input logic [1:0] p, input logic [2:0] q);
        logic [1:0] p1;
        logic [1:0] p2;
        logic [1:0] r;
        p1 = (p == 2'd2) ? 2'd0 : p + 2'd1;
        p2 = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
        if (!q[p1])      r = p1;
        else if (!q[p2]) r = p2;
        else             r = p;
        return r;
    endfunction

    assign sens_s    = bus.f1 | bus.f2 | bus.b1 | bus.b2;
    assign trig_s    = (bus.err_rate >= ERR_HI) | sens_s;
    assign calm_in_s = (bus.err_rate <= ERR_LO) & ~sens_s;

    // Mode sequencing, rotation, warm-up, hysteresis and quarantine bookkeeping
    always_comb begin
        fsm_s  = fsm_r;
        ptr_s  = ptr_r;
        quar_s = quar_r;
        rot_s  = rot_r;
        warm_s = warm_r;
        calm_s = calm_r;
        fcnt_s = fcnt_r;
        if (bus.clr_quar) begin
            fsm_s  = ST_SIMPLEX;
            ptr_s  = 2'd0;
            quar_s = 3'b000;
            rot_s  = ZERO_C;
            warm_s = ZERO_C;
            calm_s = ZERO_C;
            fcnt_s = {3{ZERO_C}};
        end else begin
            case (fsm_r)
                ST_SIMPLEX: begin
                    if (trig_s) begin
                        rot_s = ZERO_C;
                        if (quar_r == 3'b000) begin
                            fsm_s  = ST_WARMUP;
                            warm_s = ZERO_C;
                        end else begin
                            fsm_s = ST_DEGRADED;
                            ptr_s = lowest_healthy(quar_r);
                        end
                    end else if (rot_r == ROT_LAST) begin
                        rot_s = ZERO_C;
                        ptr_s = next_healthy(ptr_r, quar_r);
                    end else begin
                        rot_s = rot_r + ONE_C;
                        ptr_s = quar_r[ptr_r] ? lowest_healthy(quar_r) : ptr_r;
                    end
                end
                ST_WARMUP: begin
                    if (warm_r == WARM_LAST) begin
                        fsm_s  = ST_TMR;
                        warm_s = ZERO_C;
                        calm_s = ZERO_C;
                    end else begin
                        warm_s = warm_r + ONE_C;
                    end
                end
                ST_TMR: begin
                    for (int i = 0; i < 3; i++) begin
                        if (bus.fault[i] && (fcnt_r[i] != FLIM_C)) begin
                            fcnt_s[i] = fcnt_r[i] + ONE_C;
                        end else begin
                            fcnt_s[i] = fcnt_r[i];
                        end
                        quar_s[i] = quar_r[i] | (fcnt_s[i] == FLIM_C);
                    end
                    // A fresh quarantine outranks a calm exit on the same edge
                    if (quar_s != quar_r) begin
                        fsm_s  = ST_DEGRADED;
                        ptr_s  = lowest_healthy(quar_s);
                        calm_s = ZERO_C;
                    end else if (calm_in_s) begin
                        if (calm_r == HOLD_LAST) begin
                            fsm_s  = ST_SIMPLEX;
                            calm_s = ZERO_C;
                            rot_s  = ZERO_C;
                        end else begin
                            calm_s = calm_r + ONE_C;
                        end
                    end else begin
                        calm_s = ZERO_C;
                    end
                end
                ST_DEGRADED: begin
                    ptr_s = lowest_healthy(quar_r);
                end
                default: begin
                    fsm_s = ST_SIMPLEX;
                    ptr_s = 2'd0;
                end
            endcase
        end
    end

    // Output values for the next cycle, derived from the next mode
    always_comb begin
        en_s = 3'b001;
        case (fsm_s)
            ST_SIMPLEX:  en_s = onehot(ptr_s);
            ST_WARMUP:   en_s = ~quar_s;
            ST_TMR:      en_s = 3'b111;
            ST_DEGRADED: en_s = (quar_s == 3'b111) ? 3'b000 : onehot(lowest_healthy(quar_s));
            default:     en_s = 3'b001;
        endcase
    end

    assign state_s = (fsm_s == ST_TMR);
    assign alarm_s = (quar_s == 3'b111);

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_r   <= ST_SIMPLEX;
            ptr_r   <= 2'd0;
            quar_r  <= 3'b000;
            rot_r   <= ZERO_C;
            warm_r  <= ZERO_C;
            calm_r  <= ZERO_C;
            fcnt_r  <= {3{ZERO_C}};
            en_r    <= 3'b001;
            state_r <= 1'b0;
            alarm_r <= 1'b0;
        end else begin
            fsm_r   <= fsm_s;
            ptr_r   <= ptr_s;
            quar_r  <= quar_s;
            rot_r   <= rot_s;
            warm_r  <= warm_s;
            calm_r  <= calm_s;
            fcnt_r  <= fcnt_s;
            en_r    <= en_s;
            state_r <= state_s;
            alarm_r <= alarm_s;
        end
    end

    assign bus.en    = en_r;
    assign bus.state = state_r;
    assign bus.quar  = quar_r;
    assign bus.alarm = alarm_r;
    assign bus.fsm_o = fsm_r;

endmodule

// File: tb/tb_dtmr_sched.sv
// Bench for dtmr_sched: directed scenarios followed by randomized traffic checked
// against a cycle-level reference model of the scheduling rules.
module tb_dtmr_sched;

    localparam int HOLD = 8;
    localparam int WARM = 4;
    localparam int FLIM = 3;
    localparam int ROTP = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    dtmr_sched_if bus ();

    dtmr_sched dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    // reference model: mode 0 simplex, 1 warm-up, 2 tmr, 3 degraded
    int         m_mode, m_ptr, m_rot, m_warm, m_calm;
    int         m_fc[3];
    logic [2:0] m_quar;

    function automatic int lowest(input logic [2:0] q);
        for (int i = 0; i < 3; i++) if (!q[i]) return i;
        return 0;
    endfunction

    function automatic logic [2:0] exp_en();
        logic [2:0] one = 3'b001;
        case (m_mode)
            0: return one << m_ptr;
            1: return ~m_quar;
            2: return 3'b111;
            default: return (m_quar == 3'b111) ? 3'b000 : (one << lowest(m_quar));
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_ptr = 0; m_rot = 0; m_warm = 0; m_calm = 0;
        m_quar = 3'b000;
        for (int i = 0; i < 3; i++) m_fc[i] = 0;
    endtask

    task automatic model_step();
        bit sens, trig, calm, found;
        int cand;
        logic [2:0] nq;
        sens = bus.f1 | bus.f2 | bus.b1 | bus.b2;
        trig = (bus.err_rate >= 4'd8) || sens;
        calm = (bus.err_rate <= 4'd4) && !sens;
        if (bus.clr_quar) begin
            model_reset();
        end else begin
            case (m_mode)
                0: begin
                    if (trig) begin
                        m_rot = 0;
                        if (m_quar == 3'b000) begin m_mode = 1; m_warm = 0; end
                        else begin m_mode = 3; m_ptr = lowest(m_quar); end
                    end else begin
                        m_rot++;
                        if (m_rot == ROTP) begin
                            m_rot = 0;
                            found = 1'b0;
                            for (int k = 1; k < 3; k++) begin
                                cand = (m_ptr + k) % 3;
                                if (!found && !m_quar[cand]) begin m_ptr = cand; found = 1'b1; end
                            end
                        end else if (m_quar[m_ptr]) begin
                            m_ptr = lowest(m_quar);
                        end
                    end
                end
                1: begin
                    m_warm++;
                    if (m_warm == WARM) begin m_mode = 2; m_warm = 0; m_calm = 0; end
                end
                2: begin
                    nq = m_quar;
                    for (int i = 0; i < 3; i++) begin
                        if (bus.fault[i] && m_fc[i] < FLIM) m_fc[i]++;
                        if (m_fc[i] >= FLIM) nq[i] = 1'b1;
                    end
                    if (nq != m_quar) begin
                        m_quar = nq; m_mode = 3; m_ptr = lowest(nq); m_calm = 0;
                    end else if (calm) begin
                        m_calm++;
                        if (m_calm == HOLD) begin m_mode = 0; m_calm = 0; m_rot = 0; end
                    end else begin
                        m_calm = 0;
                    end
                end
                default: m_ptr = lowest(m_quar);
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_reset();
        else model_step();
        #1;
    endtask

    task automatic go_warm(input logic [3:0] hold_err);
        bus.err_rate = 4'd9;
        tick();
        bus.err_rate = hold_err;
    endtask

    task automatic test_reset();
        bus.err_rate = 4'd0; bus.f1 = 1'b0; bus.f2 = 1'b0; bus.b1 = 1'b0; bus.b2 = 1'b0;
        bus.fault = 3'b000; bus.clr_quar = 1'b0;
        rst = 1'b0;
        repeat (2) tick();
        total++; if (bus.en !== 3'b001) begin bad++; $display("FAIL reset_en: got %b want 001", bus.en); end
        total++; if (bus.state !== 1'b0) begin bad++; $display("FAIL reset_state: got %b want 0", bus.state); end
        total++; if (bus.quar !== 3'b000 || bus.alarm !== 1'b0) begin
            bad++; $display("FAIL reset_quar: got quar=%b alarm=%b want 000/0", bus.quar, bus.alarm);
        end
        total++; if (bus.fsm_o !== 2'd0) begin bad++; $display("FAIL reset_fsm: got %0d want 0", bus.fsm_o); end
        rst = 1'b1;
    endtask

    task automatic test_rotation();
        logic [2:0] one = 3'b001;
        logic [2:0] want;
        for (int c = 1; c <= 48; c++) begin
            tick();
            want = one << ((c / ROTP) % 3);
            total++; if (bus.en !== want || bus.state !== 1'b0) begin
                bad++; $display("FAIL rotation cyc%0d: got en=%b st=%b want en=%b st=0", c, bus.en, bus.state, want);
            end
        end
    endtask

    task automatic test_hysteresis();
        go_warm(4'd2);
        for (int k = 0; k < WARM; k++) begin
            if (k > 0) tick();
            total++; if (bus.fsm_o !== 2'd1 || bus.en !== 3'b111 || bus.state !== 1'b0) begin
                bad++; $display("FAIL warmup k%0d: got fsm=%0d en=%b st=%b want 1/111/0", k, bus.fsm_o, bus.en, bus.state);
            end
        end
        tick();
        total++; if (bus.state !== 1'b1 || bus.fsm_o !== 2'd2) begin
            bad++; $display("FAIL tmr_entry: got st=%b fsm=%0d want 1/2", bus.state, bus.fsm_o);
        end
        for (int k = 1; k < HOLD; k++) begin
            tick();
            total++; if (bus.state !== 1'b1) begin bad++; $display("FAIL hold calm%0d: got st=%b want 1", k, bus.state); end
        end
        tick();
        total++; if (bus.state !== 1'b0 || bus.en !== 3'b001) begin
            bad++; $display("FAIL hold_exit: got st=%b en=%b want 0/001", bus.state, bus.en);
        end
        go_warm(4'd2);
        repeat (WARM) tick();
        repeat (5) tick();
        bus.f1 = 1'b1;
        tick();
        bus.f1 = 1'b0;
        for (int k = 1; k < HOLD; k++) begin
            tick();
            total++; if (bus.state !== 1'b1) begin bad++; $display("FAIL restart calm%0d: got st=%b want 1", k, bus.state); end
        end
        tick();
        total++; if (bus.state !== 1'b0) begin bad++; $display("FAIL restart_exit: got st=%b want 0", bus.state); end
    endtask

    task automatic test_quar_single();
        go_warm(4'd6);
        repeat (WARM) tick();
        total++; if (bus.state !== 1'b1) begin bad++; $display("FAIL qs_tmr: got st=%b want 1", bus.state); end
        for (int p = 0; p < 3; p++) begin
            bus.fault = 3'b010; tick();
            bus.fault = 3'b000; tick();
        end
        total++; if (bus.quar !== 3'b010 || bus.fsm_o !== 2'd3 || bus.state !== 1'b0 || bus.en !== 3'b001) begin
            bad++; $display("FAIL quar_single: got q=%b fsm=%0d st=%b en=%b want 010/3/0/001", bus.quar, bus.fsm_o, bus.state, bus.en);
        end
        bus.clr_quar = 1'b1; tick(); bus.clr_quar = 1'b0;
        total++; if (bus.quar !== 3'b000 || bus.fsm_o !== 2'd0 || bus.en !== 3'b001) begin
            bad++; $display("FAIL qs_clear: got q=%b fsm=%0d en=%b want 000/0/001", bus.quar, bus.fsm_o, bus.en);
        end
    endtask

    task automatic test_quar_double();
        go_warm(4'd6);
        repeat (WARM) tick();
        bus.fault = 3'b101;
        repeat (3) tick();
        bus.fault = 3'b000;
        total++; if (bus.quar !== 3'b101 || bus.en !== 3'b010 || bus.fsm_o !== 2'd3) begin
            bad++; $display("FAIL quar_double: got q=%b en=%b fsm=%0d want 101/010/3", bus.quar, bus.en, bus.fsm_o);
        end
        bus.fault = 3'b010; tick(); bus.fault = 3'b000;
        total++; if (bus.alarm !== 1'b0 || bus.quar !== 3'b101) begin
            bad++; $display("FAIL degraded_fault: got alarm=%b q=%b want 0/101", bus.alarm, bus.quar);
        end
        bus.clr_quar = 1'b1; tick(); bus.clr_quar = 1'b0;
    endtask

    task automatic test_all_quar();
        go_warm(4'd6);
        repeat (WARM) tick();
        bus.fault = 3'b111;
        repeat (3) tick();
        total++; if (bus.alarm !== 1'b1 || bus.en !== 3'b000 || bus.quar !== 3'b111) begin
            bad++; $display("FAIL all_quar: got alarm=%b en=%b q=%b want 1/000/111", bus.alarm, bus.en, bus.quar);
        end
        bus.clr_quar = 1'b1; tick();
        bus.clr_quar = 1'b0; bus.fault = 3'b000;
        total++; if (bus.quar !== 3'b000 || bus.fsm_o !== 2'd0 || bus.en !== 3'b001 || bus.alarm !== 1'b0) begin
            bad++; $display("FAIL clr_vs_fault: got q=%b fsm=%0d en=%b alarm=%b want 000/0/001/0", bus.quar, bus.fsm_o, bus.en, bus.alarm);
        end
        bus.err_rate = 4'd0;
    endtask

    task automatic test_async_reset();
        go_warm(4'd0);
        tick();
        total++; if (bus.fsm_o !== 2'd1 || bus.en !== 3'b111) begin
            bad++; $display("FAIL ar_warm: got fsm=%0d en=%b want 1/111", bus.fsm_o, bus.en);
        end
        #2 rst = 1'b0;
        #1;
        total++; if (bus.en !== 3'b001 || bus.state !== 1'b0 || bus.fsm_o !== 2'd0) begin
            bad++; $display("FAIL async_reset: got en=%b st=%b fsm=%0d want 001/0/0", bus.en, bus.state, bus.fsm_o);
        end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 800; c++) begin
            r = int'($urandom_range(0, 99));
            if (r < 85)      bus.err_rate = 4'($urandom_range(0, 4));
            else if (r < 95) bus.err_rate = 4'($urandom_range(5, 7));
            else             bus.err_rate = 4'($urandom_range(8, 15));
            bus.f1 = ($urandom_range(0, 99) < 2);
            bus.f2 = ($urandom_range(0, 99) < 2);
            bus.b1 = ($urandom_range(0, 99) < 2);
            bus.b2 = ($urandom_range(0, 99) < 2);
            bus.fault = ($urandom_range(0, 99) < 15) ? 3'($urandom_range(1, 7)) : 3'b000;
            bus.clr_quar = ($urandom_range(0, 99) < 2);
            tick();
            total++; if (bus.en !== exp_en() || bus.state !== (m_mode == 2) || bus.quar !== m_quar ||
                         bus.alarm !== (m_quar == 3'b111) || bus.fsm_o !== 2'(m_mode)) begin
                bad++;
                $display("FAIL random cyc%0d: got en=%b st=%b q=%b al=%b fsm=%0d want en=%b st=%b q=%b al=%b fsm=%0d",
                         c, bus.en, bus.state, bus.quar, bus.alarm, bus.fsm_o,
                         exp_en(), (m_mode == 2), m_quar, (m_quar == 3'b111), m_mode);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rotation();
        test_hysteresis();
        test_quar_single();
        test_quar_double();
        test_all_quar();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
